if_fetch_unit: RTL

//   Instruction-fetch initiator for the pipelined MIPS core. It drives PC_F into
//   the combinational instruction memory and captures the returned word into the
//   IF/ID pipeline register. It computes the next PC from the D-stage redirect
//   (branch, j/jal, jr) and supports stall, flush and fetch-address faults.

---
 rtl/if_fetch_unit.sv | 92 +++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: drives PC_F to the instruction memory, computes the
// next PC from the D-stage redirect and holds the IF/ID pipeline register.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int          IM_WORDS = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush_D,
   input  logic [1:0]  npc_sel,
   input  logic [15:0] imm16_D,
   input  logic [25:0] index26_D,
   input  logic [31:0] rs_D,
   input  logic [31:0] Instr_F,
   output logic [31:0] PC_F,
   output logic [31:0] Instr_D,
   output logic [31:0] PC_D,
   output logic [31:0] PC8_D,
   output logic        valid_D,
   output logic        adel_D
);

   localparam logic [31:0] LP_LAST = RESET_PC + 32'(4 * IM_WORDS) - 32'd1;

   logic [31:0] r_pc_f;
   logic [31:0] r_instr_d;
   logic [31:0] r_pc_d;
   logic [31:0] r_pc8_d;
   logic        r_valid_d;
   logic        r_adel_d;

   logic [31:0] w_pcd_plus4;
   logic [31:0] w_br_off;
   logic [31:0] w_npc;
   logic        w_fault;

   assign w_pcd_plus4 = r_pc_d + 32'd4;
   assign w_br_off    = {{14{imm16_D[15]}}, imm16_D, 2'b00};

   always_comb begin
      w_npc = r_pc_f + 32'd4;
      unique case (npc_sel)
         2'b00: w_npc = r_pc_f + 32'd4;
         2'b01: w_npc = w_pcd_plus4 + w_br_off;
         2'b10: w_npc = {w_pcd_plus4[31:28], index26_D, 2'b00};
         2'b11: w_npc = rs_D;
         default: w_npc = r_pc_f + 32'd4;
      endcase
   end

   // Misaligned or outside the IM window; a wrapped PC lands below the window.
   assign w_fault = (r_pc_f[1:0] != 2'b00) |
                    (r_pc_f < RESET_PC) |
                    (r_pc_f > LP_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc_f    <= RESET_PC;
         r_instr_d <= 32'd0;
         r_pc_d    <= RESET_PC;
         r_pc8_d   <= RESET_PC + 32'd8;
         r_valid_d <= 1'b0;
         r_adel_d  <= 1'b0;
      end else if (!stall) begin
         r_pc_f  <= w_npc;
         r_pc_d  <= r_pc_f;
         r_pc8_d <= r_pc_f + 32'd8;
         if (flush_D) begin
            r_instr_d <= 32'd0;
            r_valid_d <= 1'b0;
            r_adel_d  <= 1'b0;
         end else if (w_fault) begin
            r_instr_d <= 32'd0;
            r_valid_d <= 1'b1;
            r_adel_d  <= 1'b1;
         end else begin
            r_instr_d <= Instr_F;
            r_valid_d <= 1'b1;
            r_adel_d  <= 1'b0;
         end
      end
   end

   assign PC_F    = r_pc_f;
   assign Instr_D = r_instr_d;
   assign PC_D    = r_pc_d;
   assign PC8_D   = r_pc8_d;
   assign valid_D = r_valid_d;
   assign adel_D  = r_adel_d;

endmodule
